// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier (signed, one multiplier bit retired per clock).
// Optional early termination when remaining multiplier bits are uniform: define BMUL_EARLY_TERM_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one add/sub + arithmetic shift per cycle
// DONE  | product valid, done pulse; start here restarts back-to-back
module booth_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH:0]     a, m, a_sum;
  logic [WIDTH-1:0]   q;
  logic               q_1;
  logic [CNT_W-1:0]   cnt;
  logic               accept, last_step;
  logic [2*WIDTH+1:0] next_vec;

  assign accept = start && ((state == IDLE) || (state == DONE));

  // One Booth step on the WIDTH+1-bit accumulator, then shift {A,Q,q_1}.
  always_comb begin
    a_sum = a;
    case ({q[0], q_1})
      2'b10:   a_sum = a - m;
      2'b01:   a_sum = a + m;
      default: a_sum = a;
    endcase
    next_vec  = $signed({a_sum, q, q_1}) >>> 1;
    last_step = (cnt == CNT_LAST);
`ifdef BMUL_EARLY_TERM_EN
    begin
      localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
      localparam logic [WIDTH-1:0] ONES    = '1;
      // Unretired bits all equal q_1 means only 00/11 pairs remain: shifts only.
      if (((q ^ {WIDTH{q_1}}) & (ONES >> cnt)) == '0) begin
        next_vec  = $signed({a, q, q_1}) >>> (WIDTH_C - cnt);
        last_step = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      a   <= '0;
      q   <= multiplier;
      q_1 <= 1'b0;
      m   <= {multiplicand[WIDTH-1], multiplicand};
      cnt <= '0;
    end else if (state == RUN) begin
      {a, q, q_1} <= next_vec;
      cnt         <= cnt + CNT_W'(1);
      if (last_step) product <= next_vec[2*WIDTH:1];
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: timestamp-based reference model plus directed vectors.
// Covers WIDTH=8 directed/random operations and an exhaustive WIDTH=4 sweep.
module tb_booth_mul_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [W-1:0] mcand = '0, mplier = '0;
  logic busy, done;
  logic [2*W-1:0] product;

  logic start4 = 1'b0;
  logic [3:0] m4 = '0, q4 = '0;
  logic busy4, done4;
  logic [7:0] product4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .multiplicand(mcand), .multiplier(mplier),
    .busy(busy), .done(done), .product(product));

  booth_mul_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .multiplicand(m4), .multiplier(q4),
    .busy(busy4), .done(done4), .product(product4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted start at edge e0 gives RUN for WIDTH cycles, then one DONE cycle.
  longint e = 0;
  longint e0 = 0;
  bit active = 1'b0;
  bit prev_busy;
  logic [2*W-1:0] exp_prod = '0;
  logic [2*W-1:0] pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   = 1'b0;
      exp_prod = '0;
    end else begin
      e++;
      prev_busy = active && (e - 1 >= e0) && (e - 1 < e0 + W);
      if (active && e == e0 + W) exp_prod = pend;
      if (start && !prev_busy) begin
        int mi, qi;
        mi     = mcand;
        qi     = mplier;
        pend   = 16'(mi * qi);
        e0     = e;
        active = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'b0, busy}, {31'b0, active && e >= e0 && e < e0 + W});
      chk("done", {31'b0, done}, {31'b0, active && e == e0 + W});
      chk("product", {16'b0, product}, {16'b0, exp_prod});
    end
  end

  task automatic do_op(input int mi, input int qi, output int lat, output int nbusy,
                       output logic [2*W-1:0] p);
    @(negedge clk);
    mcand  = W'(mi);
    mplier = W'(qi);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = W'($urandom);
    mplier = W'($urandom);
    lat    = 1;
    nbusy  = 0;
    while (!done && lat < 40) begin
      nbusy += int'(busy);
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) chk("done_timeout", 32'(lat), 32'(W + 1));
    p = product;
  endtask

  typedef struct {
    int m;
    int q;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[8] = '{
    '{7, 3, 16'h0015},
    '{-128, -128, 16'h4000},
    '{-128, 127, 16'hC080},
    '{-1, -1, 16'h0001},
    '{0, -77, 16'h0000},
    '{93, 0, 16'h0000},
    '{127, 127, 16'h3F01},
    '{-1, 1, 16'hFFFF}
  };

  initial begin
    int lat, nbusy, ndone, gap, n;
    logic [2*W-1:0] p;

    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_product", {16'b0, product}, 32'd0);
    chk("rst_product4", {24'b0, product4}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].m, vecs[i].q, lat, nbusy, p);
      chk($sformatf("vec%0d_product", i), {16'b0, p}, {16'b0, vecs[i].p});
      chk($sformatf("vec%0d_model", i), {16'b0, exp_prod}, {16'b0, vecs[i].p});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(nbusy), 32'(W));
    end

    // start during RUN is ignored
    @(negedge clk);
    mcand = 8'sd10; mplier = -8'sd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; mcand = 8'sd50; mplier = 8'sd50; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0;
    p = '0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        p = product;
      end
    end
    chk("ignored_start_pulses", 32'(ndone), 32'd1);
    chk("ignored_start_product", {16'b0, p}, 32'h0000FFE2);

    // start held through DONE: back-to-back
    @(negedge clk);
    mcand = 8'sd3; mplier = 8'sd4; start = 1'b1;
    @(posedge clk); #1;
    mcand = -8'sd2; mplier = 8'sd5;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b_first_product", {16'b0, product}, 32'h0000000C);
    gap = 0;
    @(posedge clk); #1; start = 1'b0; gap++;
    chk("b2b_product_held", {16'b0, product}, 32'h0000000C);
    while (!done && gap < 40) begin
      @(posedge clk); #1; gap++;
    end
    chk("b2b_gap", 32'(gap), 32'(W + 1));
    chk("b2b_second_product", {16'b0, product}, 32'h0000FFF6);

    // reset mid-RUN
    @(negedge clk);
    mcand = 8'sd100; mplier = -8'sd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_product", {16'b0, product}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op(-7, 6, lat, nbusy, p);
    chk("after_rst_product", {16'b0, p}, 32'h0000FFD6);
    chk("after_rst_latency", 32'(lat), 32'(W + 1));

    for (int k = 0; k < 60; k++) begin
      int mi, qi;
      mi = int'($urandom_range(0, 255)) - 128;
      qi = int'($urandom_range(0, 255)) - 128;
      do_op(mi, qi, lat, nbusy, p);
      chk("rand_product", {16'b0, p}, {16'b0, 16'(mi * qi)});
    end

    // exhaustive WIDTH=4
    for (int mi = -8; mi < 8; mi++) begin
      for (int qi = -8; qi < 8; qi++) begin
        @(negedge clk);
        m4 = 4'(mi); q4 = 4'(qi); start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
          @(posedge clk); #1; n++;
        end
        chk("w4_latency", 32'(n), 32'd4);
        chk("w4_product", {24'b0, product4}, {24'b0, 8'(mi * qi)});
      end
    end
    chk("w4_idle_busy", {31'b0, busy4}, 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
